// File: rtl/seg7_scan_mux_if.sv
// Display-side bus of seg7_scan_mux: digit data and controls in, multiplexed pins out.
// master = numeric datapath / bench, slave = the scan multiplexer.
interface seg7_scan_mux_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BRIGHT_W   = 4
);
    logic                    enable;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic [BRIGHT_W-1:0]     brightness;

    logic [6:0]              seg_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   an_out;
    logic                    frame_start;

    modport master (
        output enable, digits_in, dp_in, blank_in, brightness,
        input  seg_out, dp_out, an_out, frame_start
    );

    modport slave (
        input  enable, digits_in, dp_in, blank_in, brightness,
        output seg_out, dp_out, an_out, frame_start
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// Parametrised seven-segment scan multiplexer with prescaler, PWM brightness and frame snapshot.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (auto-blank leading zero digits at snapshot).
module seg7_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int BRIGHT_W   = 4
) (
    input  logic            clk_in,
    input  logic            rst,
    seg7_scan_mux_if.slave  bus
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [PW-1:0]           prescaler;
    logic [BRIGHT_W-1:0]     phase;
    logic [IW-1:0]           idx;
    logic                    primed;
    logic [4*NUM_DIGITS-1:0] digit_snap;
    logic [NUM_DIGITS-1:0]   dp_snap;
    logic [NUM_DIGITS-1:0]   blank_snap;

    logic                    tick;
    logic                    phase_wrap;
    logic                    idx_last;
    logic                    frame_wrap;
    logic [NUM_DIGITS-1:0]   lz_blank;

    logic [3:0]              cur_digit;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [6:0]              seg_next;
    logic                    dp_next;
    logic [NUM_DIGITS-1:0]   an_next;
    logic                    frame_next;

    logic [6:0]              seg_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic                    frame_q;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'b1000000;
            4'h1: hex_to_seg = 7'b1111001;
            4'h2: hex_to_seg = 7'b0100100;
            4'h3: hex_to_seg = 7'b0110000;
            4'h4: hex_to_seg = 7'b0011001;
            4'h5: hex_to_seg = 7'b0010010;
            4'h6: hex_to_seg = 7'b0000010;
            4'h7: hex_to_seg = 7'b1111000;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0010000;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b0000011;
            4'hC: hex_to_seg = 7'b1000110;
            4'hD: hex_to_seg = 7'b0100001;
            4'hE: hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    assign tick       = (prescaler == PW'(CLK_DIV - 1));
    assign phase_wrap = &phase;
    assign idx_last   = (idx == IW'(NUM_DIGITS - 1));
    assign frame_wrap = phase_wrap && idx_last;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic seen_nonzero;

    // Walk down from the top digit; everything above the first nonzero nibble goes dark.
    always_comb begin
        lz_blank     = '0;
        seen_nonzero = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (bus.digits_in[4*i +: 4] != 4'h0) begin
                seen_nonzero = 1'b1;
            end
            lz_blank[i] = !seen_nonzero;
        end
    end
`else
    assign lz_blank = '0;
`endif

    // Scan counters; the snapshot reloads only at a frame boundary so a frame never tears.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            prescaler  <= '0;
            phase      <= '0;
            idx        <= '0;
            primed     <= 1'b0;
            digit_snap <= '0;
            dp_snap    <= '0;
            blank_snap <= '0;
        end else begin
            if (tick) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + PW'(1);
            end

            if (tick) begin
                phase <= phase + BRIGHT_W'(1);
                if (phase_wrap) begin
                    idx <= idx_last ? '0 : idx + IW'(1);
                end
                if (frame_wrap || !primed) begin
                    primed     <= 1'b1;
                    digit_snap <= bus.digits_in;
                    dp_snap    <= bus.dp_in;
                    blank_snap <= bus.blank_in | lz_blank;
                end
            end
        end
    end

    always_comb begin
        cur_digit = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_digit = digit_snap[4*i +: 4];
                cur_dp    = dp_snap[i];
                cur_blank = blank_snap[i];
            end
        end

        seg_next   = hex_to_seg(cur_digit);
        dp_next    = ~cur_dp;
        an_next    = '1;
        // phase < brightness can never hold on the all-ones phase, which keeps the ghosting guard tick dark.
        if (bus.enable && !cur_blank && (phase < bus.brightness)) begin
            an_next = ~(NUM_DIGITS'(1) << idx);
        end
        frame_next = (prescaler == '0) && (phase == '0) && (idx == '0);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            an_q    <= '1;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_next;
            dp_q    <= dp_next;
            an_q    <= an_next;
            frame_q <= frame_next;
        end
    end

    assign bus.seg_out     = seg_q;
    assign bus.dp_out      = dp_q;
    assign bus.an_out      = an_q;
    assign bus.frame_start = frame_q;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: a time-based reference model queues expected pins per clock,
// and a monitor pops and compares them one tick after every rising edge.
module tb_seg7_scan_mux;
    localparam int ND    = 4;
    localparam int CD    = 4;
    localparam int BW    = 2;
    localparam int P     = 1 << BW;
    localparam int FRAME = ND * P * CD;

    typedef struct {
        logic [6:0]    seg;
        logic          dp;
        logic [ND-1:0] an;
        logic          fs;
        int            cyc;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    seg7_scan_mux_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bus ();

    seg7_scan_mux #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BRIGHT_W(BW)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: display state derived from the number of edges since reset release.
    int              cyc;
    logic [4*ND-1:0] snap_dig;
    logic [ND-1:0]   snap_dp;
    logic [ND-1:0]   snap_blank;

    logic [6:0] seg_table [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic modelReset();
        cyc        = 0;
        snap_dig   = '0;
        snap_dp    = '0;
        snap_blank = '0;
    endtask

    task automatic pushExpected();
        exp_t e;
        int   t;
        int   ph;
        int   id;
        int   msd;
        cyc++;
        t  = (cyc - 1) / CD;
        ph = t % P;
        id = (t / P) % ND;
        e.cyc = cyc;
        e.fs  = (((cyc - 1) % CD) == 0) && ((t % (P * ND)) == 0);
        e.seg = seg_table[snap_dig[4*id +: 4]];
        e.dp  = ~snap_dp[id];
        e.an  = '1;
        if (bus.enable && !snap_blank[id] && (ph < int'(bus.brightness))) e.an[id] = 1'b0;
        sbq.push_back(e);
        // Capture on the first tick after release and whenever a whole number of frames has elapsed.
        if ((cyc % CD) == 0 && (cyc == CD || ((cyc / CD) % (P * ND)) == 0)) begin
            snap_dig   = bus.digits_in;
            snap_dp    = bus.dp_in;
            snap_blank = bus.blank_in;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            msd = 0;
            for (int i = 0; i < ND; i++) if (bus.digits_in[4*i +: 4] != 4'h0) msd = i;
            for (int i = 1; i < ND; i++) if (i > msd) snap_blank[i] = 1'b1;
`else
            msd = 0;
`endif
        end
    endtask

    task automatic compareField(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d actual=%0h required=%0h", name, c, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField("seg_out", e.cyc, 32'(bus.seg_out), 32'(e.seg));
        compareField("dp_out", e.cyc, 32'(bus.dp_out), 32'(e.dp));
        compareField("an_out", e.cyc, 32'(bus.an_out), 32'(e.an));
        compareField("frame_start", e.cyc, 32'(bus.frame_start), 32'(e.fs));
    endtask

    task automatic checkReset(input string tag);
        compareField({tag, "_seg"}, 0, 32'(bus.seg_out), 32'h7F);
        compareField({tag, "_dp"}, 0, 32'(bus.dp_out), 32'h1);
        compareField({tag, "_an"}, 0, 32'(bus.an_out), 32'hF);
        compareField({tag, "_fs"}, 0, 32'(bus.frame_start), 32'h0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checkOutput(e);
            end
        end
    end

    // Called at a negedge; leaves the bench at a negedge. mode 1 randomises inputs as it goes.
    task automatic applyStimulus(input int n, input int mode);
        for (int k = 0; k < n; k++) begin
            if (mode == 1) begin
                if ($urandom_range(7) == 0) begin
                    bus.digits_in = 16'($urandom);
                    bus.dp_in     = 4'($urandom);
                    bus.blank_in  = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
                end
                if ($urandom_range(15) == 0) bus.brightness = 2'($urandom);
                if ($urandom_range(31) == 0) bus.enable = ~bus.enable;
            end
            pushExpected();
            @(negedge clk_in);
        end
    endtask

    task automatic releaseReset();
        @(negedge clk_in);
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        bus.enable     = 1'b1;
        bus.digits_in  = 16'h1234;
        bus.dp_in      = 4'b0000;
        bus.blank_in   = 4'b0000;
        bus.brightness = 2'd3;
        modelReset();
        repeat (3) @(posedge clk_in);
        #2;
        checkReset("reset");
        releaseReset();
        applyStimulus(2 * FRAME, 0);

        for (int b = 0; b < P; b++) begin
            bus.brightness = 2'(b);
            applyStimulus(FRAME, 0);
        end

        applyStimulus(FRAME / 2 + 3, 0);
        bus.digits_in = 16'hABCD;
        applyStimulus(FRAME + FRAME / 2, 0);

        bus.blank_in = 4'b0100;
        bus.dp_in    = 4'b0001;
        applyStimulus(2 * FRAME, 0);
        bus.blank_in = 4'b0000;

        applyStimulus(7, 0);
        bus.enable = 1'b0;
        applyStimulus(21, 0);
        bus.enable = 1'b1;
        bus.brightness = 2'd1;
        applyStimulus(9, 0);
        bus.brightness = 2'd3;
        applyStimulus(FRAME, 0);

        // Re-align to a fresh frame, run into slot 2, then pull reset between clock edges.
        rst = 1'b1;
        releaseReset();
        applyStimulus(2 * P * CD + 5, 0);
        @(posedge clk_in);
        #3;
        rst = 1'b1;
        #1;
        checkReset("async_rst");
        releaseReset();
        applyStimulus(FRAME, 0);

        bus.digits_in = 16'h0070;
        applyStimulus(2 * FRAME, 0);
        bus.digits_in = 16'h0000;
        applyStimulus(2 * FRAME, 0);

        applyStimulus(30 * FRAME, 1);

        @(posedge clk_in);
        #2;
        if (sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
